pcie_mem_req_splitter: RTL and testbench
========================================

Name: pcie_mem_req_splitter

Overview:
- Converts one application memory request (64-bit address, byte length up to 4 KB) into a sequence of PCIe memory request TLP headers, packed in the team's tlp_memory_req_hdr_t layout.
- Splits on MAX_PAYLOAD_SIZE for writes, MAX_READ_REQ_SIZE for reads, and on 4 KB address boundaries.
- Allocates and tracks read tags, which are freed by the completion path.
- Sits between the DMA engine and the transaction-layer TX arbiter. It is the parametrised successor to the fixed header package: sizes and tag count are configurable, and it adds splitting and tag flow control.

Parameters:
- MPS_BYTES, 128, maximum write payload per TLP; power of two, 128..4096.
- MRRS_BYTES, 512, maximum read request per TLP; power of two, 128..4096.
- TAG_COUNT, 32, number of outstanding read tags; power of two, 2..256.
- LEN_WIDTH, 13, width of the request byte length; maximum request is 4096 bytes.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- cfg_requester_id  in  16  {bus, dev, fn}; quasi-static.
- req_valid  in  1  request valid.
- req_ready  out  1  high only in IDLE.
- req_is_write  in  1  1 = MWr, 0 = MRd.
- req_addr  in  64  start byte address; must be DW aligned.
- req_len  in  LEN_WIDTH  byte length; must be a multiple of 4 and in 4..4096.
- hdr_valid  out  1  header valid.
- hdr_ready  in  1  downstream accepts the header.
- hdr  out  128  tlp_memory_req_hdr_t.
- hdr_last  out  1  final header of the current request.
- tag_free_valid  in  1  a completion retired a tag.
- tag_free  in  $clog2(TAG_COUNT)  tag being freed.
- tags_in_flight  out  $clog2(TAG_COUNT)+1  number of tags currently reserved.
- err  out  1  one-cycle pulse on a dropped request or an illegal free.

Behaviour:
- Reset values:
  - state = IDLE, req_ready = 1, hdr_valid = 0, hdr = 0, hdr_last = 0.
  - Tag bitmap all free, tags_in_flight = 0, err = 0.
- Reset mid-split abandons the request. No further headers are emitted.
- States: IDLE, ALLOC, ISSUE.
- IDLE:
  - req_valid && req_ready accepts the request, latching addr, remaining = len, and is_write.
  - If len == 0, len[1:0] != 0, addr[1:0] != 0, or len > 4096: drop the request, pulse err the next cycle, stay in IDLE.
  - Otherwise go to ALLOC.
- ALLOC:
  - Write: cur_tag = 0, go to ISSUE.
  - Read: if any tag is free, reserve the lowest-index free tag into cur_tag, set its bit, go to ISSUE. Otherwise stay in ALLOC with hdr_valid = 0.
- ISSUE:
  - hdr_valid = 1.
  - chunk = min(remaining, MAX, 4096 − addr[11:0]), where MAX = MPS_BYTES for writes and MRRS_BYTES for reads.
  - hdr_last = (remaining == chunk).
  - On handshake with hdr_last: go to IDLE.
  - On handshake otherwise: addr += chunk, remaining −= chunk. Then:
    - Write, or read with a free tag available: reserve the next tag in the same cycle and stay in ISSUE (one header per cycle).
    - Read with no free tag: go to ALLOC.
- Header stability: hdr, hdr_last, and the chunk are functions of registered state only. They must stay stable while hdr_valid && !hdr_ready. There is no combinational path from hdr_ready to hdr or hdr_valid.
- Latency: request accepted at cycle N → first hdr_valid at cycle N+2 (ALLOC at N+1, ISSUE at N+2).
- Header fields:
  - fmt: 3'b011 for MWr, 3'b001 for MRd (always 4DW).
  - tlp_type = 0; tc, attr, th, td, ep, at, ln, tg = 0.
  - len_dw = chunk/4. length_h = len_dw[9:8], length_l = len_dw[7:0]. 1024 DW is encoded as 0.
  - byte_enable = {last_be, first_be}: first_be = 4'hF; last_be = 4'hF if len_dw > 1, else 4'h0.
  - tag = cur_tag (0 for writes).
  - requester_id, addr_h, addr_m, addr_l are loaded per header byte order, most significant byte in the lowest header byte:
    - requester_id[7:0] = id[15:8], requester_id[15:8] = id[7:0].
    - addr_h = byteswap32(addr[63:32]).
    - addr_m = {addr[15:8], addr[23:16], addr[31:24]}.
    - addr_l = addr[7:2], reserved = 0.
- Tag free:
  - tag_free_valid clears the bitmap bit at the end of the cycle. A freed tag is not reusable by an allocation in the same cycle.
  - Freeing a tag that is not in use is ignored and pulses err.
  - A free and an allocation in the same cycle are both applied; tags_in_flight nets to ±0.

Decomposition:
- PCIE_PKG gains:
  - fmt and type constants (FMT_4DW_NODATA, FMT_4DW_DATA, TYPE_MEM).
  - A 4 KB boundary constant.
  - A function pack_mem_req_hdr(is_write, addr, len_dw, tag, req_id) returning tlp_memory_req_hdr_t, with the byte-order rules above.
- Sub-module pcie_tag_allocator: bitmap, lowest-free priority encoder, free port, in-flight counter, err on illegal free.

Test Plan:
- Write, addr 0x1000, len 512, ready held high → 4 headers on consecutive cycles:
  - addr 0x1000/0x1080/0x1100/0x1180, len_dw 32, fmt 011, BE 0xFF, tag 0.
  - hdr_last only on the 4th.
- Read, addr 0x0FC0, len 1024 (crosses 4 KB) → chunks 64/512/448 bytes:
  - len_dw 16/128/112, addr 0x0FC0/0x1000/0x1200, tags 0/1/2.
  - tags_in_flight = 3.
- Read, addr 0x20, len 4 → single header: len_dw 1, BE 0x0F, hdr_last = 1. Then tag_free 0 → tags_in_flight = 0.
- 33 four-byte reads with no frees → tags 0..31 issued; the 33rd stalls in ALLOC with hdr_valid = 0. tag_free = 5 → next header carries tag 5.
- Error and backpressure cases:
  - len = 6, or addr = 0x2 → dropped, err pulse, no header.
  - hdr_ready low for 3 cycles mid-split → hdr and hdr_last unchanged across those cycles.
- Reset asserted mid-split → all outputs at reset values, bitmap cleared. The next read gets tag 0.

Source files
------------

// File: rtl/pcie_mem_req_splitter_pkg.sv
// pcie_mem_req_splitter_pkg: shared types and helpers for the memory request
// splitter.
// - tlp_memory_req_hdr_t is a 4DW memory request header. Header byte k sits at
//   bits [8k+7:8k], so header byte 0 ({fmt, type}) is the least significant byte.
// - pack_mem_req_hdr builds one header from a byte address, a DW length, a tag
//   and a requester id.
package pcie_mem_req_splitter_pkg;

   localparam logic [2:0] FMT_4DW_NODATA = 3'b001;
   localparam logic [2:0] FMT_4DW_DATA   = 3'b011;
   localparam logic [4:0] TYPE_MEM       = 5'b00000;
   localparam int         BOUNDARY_BYTES = 4096;
   localparam int         CHUNK_W        = 13;  // holds 0..4096

   // Fields are listed from header byte 15 (MSB) down to header byte 0 (LSB).
   typedef struct packed {
      logic [5:0]  addr_l;        // byte 15 [7:2]
      logic [1:0]  reserved;      // byte 15 [1:0]
      logic [23:0] addr_m;        // bytes 14..12
      logic [31:0] addr_h;        // bytes 11..8
      logic [7:0]  byte_enable;   // byte 7 {last_be, first_be}
      logic [7:0]  tag;           // byte 6
      logic [15:0] requester_id;  // bytes 5..4
      logic [7:0]  length_l;      // byte 3
      logic        td;            // byte 2
      logic        ep;
      logic [1:0]  attr_l;
      logic [1:0]  at;
      logic [1:0]  length_h;
      logic        tg_h;          // byte 1
      logic [2:0]  tc;
      logic        tg_m;
      logic        attr_h;
      logic        ln;
      logic        th;
      logic [2:0]  fmt;           // byte 0
      logic [4:0]  tlp_type;
   } tlp_memory_req_hdr_t;

   typedef enum logic [1:0] {ST_IDLE, ST_ALLOC, ST_ISSUE} split_state_t;

   // len_dw is 11 bits so that 1024 DW is still distinguishable for the
   // last-BE rule; the encoded length field wraps 1024 to 0.
   function automatic tlp_memory_req_hdr_t pack_mem_req_hdr(
      input logic        is_write,
      input logic [63:0] addr,
      input logic [10:0] len_dw,
      input logic [7:0]  tag,
      input logic [15:0] req_id);
      tlp_memory_req_hdr_t h;
      h              = '0;
      h.fmt          = is_write ? FMT_4DW_DATA : FMT_4DW_NODATA;
      h.tlp_type     = TYPE_MEM;
      h.length_h     = len_dw[9:8];
      h.length_l     = len_dw[7:0];
      h.requester_id = {req_id[7:0], req_id[15:8]};
      h.tag          = tag;
      h.byte_enable  = {((len_dw > 11'd1) ? 4'hF : 4'h0), 4'hF};
      h.addr_h       = {addr[39:32], addr[47:40], addr[55:48], addr[63:56]};
      h.addr_m       = {addr[15:8], addr[23:16], addr[31:24]};
      h.addr_l       = addr[7:2];
      h.reserved     = addr[1:0] & 2'b00;
      return h;
   endfunction

endpackage

// File: rtl/pcie_tag_allocator.sv
// pcie_tag_allocator: read tag bitmap with lowest-free priority encoder.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   alloc               reserve free_idx this cycle (ignored when none free)
//   free_valid/free_tag retire a tag; an unused tag is ignored and flags err
//   any_free, free_idx  lowest free tag, from the registered bitmap only, so a
//                       tag freed this cycle is not handed out until next cycle
//   in_flight           number of reserved tags
//   err                 one-cycle pulse after an illegal free
module pcie_tag_allocator #(
   parameter int TAG_COUNT = 32
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           alloc,
   input  logic                           free_valid,
   input  logic [$clog2(TAG_COUNT)-1:0]   free_tag,
   output logic                           any_free,
   output logic [$clog2(TAG_COUNT)-1:0]   free_idx,
   output logic [$clog2(TAG_COUNT):0]     in_flight,
   output logic                           err
);
   localparam int TAG_W = $clog2(TAG_COUNT);

   logic [TAG_COUNT-1:0] busy_q, busy_d;
   logic                 take, free_ok;

   // Descending scan: the last assignment wins, leaving the lowest free index.
   always_comb begin
      any_free = 1'b0;
      free_idx = '0;
      for (int i = TAG_COUNT - 1; i >= 0; i--) begin
         if (!busy_q[i]) begin
            any_free = 1'b1;
            free_idx = TAG_W'(i);
         end
      end
   end

   assign take    = alloc && any_free;
   assign free_ok = free_valid && busy_q[free_tag];

   // The allocated tag is free and the freed tag is busy, so the two never
   // touch the same bit.
   always_comb begin
      busy_d = busy_q;
      if (take)    busy_d[free_idx] = 1'b1;
      if (free_ok) busy_d[free_tag] = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         busy_q    <= '0;
         in_flight <= '0;
         err       <= 1'b0;
      end else begin
         busy_q    <= busy_d;
         in_flight <= in_flight + (TAG_W + 1)'(take) - (TAG_W + 1)'(free_ok);
         err       <= free_valid && !busy_q[free_tag];
      end
   end

endmodule

// File: rtl/pcie_mem_req_splitter.sv
// pcie_mem_req_splitter: splits one DMA memory request into 4DW MWr/MRd
// headers on MPS (writes), MRRS (reads) and 4 KB boundaries, reserving a read
// tag per MRd header.
// Ports:
//   clk, rst                    clock, synchronous active-high reset
//   cfg_requester_id            {bus, dev, fn}
//   req_valid/req_ready         request handshake (ready only in IDLE)
//   req_is_write/addr/len       request: 1 = MWr, DW-aligned address, bytes
//   hdr_valid/hdr_ready         header handshake towards the TX arbiter
//   hdr, hdr_last               packed header, final header of the request
//   tag_free_valid/tag_free     completion path retires a read tag
//   tags_in_flight              reserved tag count
//   err                         pulse on dropped request or illegal free
module pcie_mem_req_splitter
   import pcie_mem_req_splitter_pkg::*;
#(
   parameter int MPS_BYTES  = 128,
   parameter int MRRS_BYTES = 512,
   parameter int TAG_COUNT  = 32,
   parameter int LEN_WIDTH  = 13
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [15:0]                   cfg_requester_id,
   input  logic                          req_valid,
   output logic                          req_ready,
   input  logic                          req_is_write,
   input  logic [63:0]                   req_addr,
   input  logic [LEN_WIDTH-1:0]          req_len,
   output logic                          hdr_valid,
   input  logic                          hdr_ready,
   output logic [127:0]                  hdr,
   output logic                          hdr_last,
   input  logic                          tag_free_valid,
   input  logic [$clog2(TAG_COUNT)-1:0]  tag_free,
   output logic [$clog2(TAG_COUNT):0]    tags_in_flight,
   output logic                          err
);
   localparam int TAG_W = $clog2(TAG_COUNT);

   split_state_t         state;
   logic [63:0]          addr_q;
   logic [CHUNK_W-1:0]   rem_q;
   logic                 is_write_q;
   logic [TAG_W-1:0]     cur_tag_q;
   logic                 drop_err_q;

   logic [CHUNK_W-1:0]   max_bytes, to_bnd, chunk;
   logic                 last, hdr_fire, bad_req, alloc;
   logic                 any_free, tag_err;
   logic [TAG_W-1:0]     free_idx;

   // Chunk depends only on registered state, so the header holds still under
   // backpressure and hdr_ready never reaches hdr combinationally.
   always_comb begin
      max_bytes = is_write_q ? CHUNK_W'(MPS_BYTES) : CHUNK_W'(MRRS_BYTES);
      to_bnd    = CHUNK_W'(BOUNDARY_BYTES) - {1'b0, addr_q[11:0]};
      chunk     = rem_q;
      if (max_bytes < chunk) chunk = max_bytes;
      if (to_bnd < chunk)    chunk = to_bnd;
   end

   assign last     = (rem_q == chunk);
   assign hdr_fire = hdr_valid && hdr_ready;
   assign bad_req  = (req_len == '0) || (req_len[1:0] != 2'b00) ||
                     (req_addr[1:0] != 2'b00) ||
                     (32'(req_len) > 32'(BOUNDARY_BYTES));

   // Reads reserve a tag on entering ISSUE and on every non-final handshake.
   assign alloc = !is_write_q &&
                  ((state == ST_ALLOC) || (state == ST_ISSUE && hdr_fire && !last));

   pcie_tag_allocator #(.TAG_COUNT(TAG_COUNT)) u_tags (
      .clk        (clk),
      .rst        (rst),
      .alloc      (alloc),
      .free_valid (tag_free_valid),
      .free_tag   (tag_free),
      .any_free   (any_free),
      .free_idx   (free_idx),
      .in_flight  (tags_in_flight),
      .err        (tag_err)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= ST_IDLE;
         addr_q     <= '0;
         rem_q      <= '0;
         is_write_q <= 1'b0;
         cur_tag_q  <= '0;
         drop_err_q <= 1'b0;
      end else begin
         drop_err_q <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (req_valid) begin
                  if (bad_req) begin
                     drop_err_q <= 1'b1;
                  end else begin
                     addr_q     <= req_addr;
                     rem_q      <= CHUNK_W'(req_len);
                     is_write_q <= req_is_write;
                     state      <= ST_ALLOC;
                  end
               end
            end
            ST_ALLOC: begin
               if (is_write_q) begin
                  cur_tag_q <= '0;
                  state     <= ST_ISSUE;
               end else if (any_free) begin
                  cur_tag_q <= free_idx;
                  state     <= ST_ISSUE;
               end
            end
            ST_ISSUE: begin
               if (hdr_fire) begin
                  if (last) begin
                     state <= ST_IDLE;
                  end else begin
                     addr_q <= addr_q + 64'(chunk);
                     rem_q  <= rem_q - chunk;
                     if (is_write_q)    cur_tag_q <= '0;
                     else if (any_free) cur_tag_q <= free_idx;
                     else               state     <= ST_ALLOC;
                  end
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   assign req_ready = (state == ST_IDLE);
   assign hdr_valid = (state == ST_ISSUE);
   assign hdr_last  = hdr_valid && last;
   assign hdr       = hdr_valid ? pack_mem_req_hdr(is_write_q, addr_q,
                                                   chunk[12:2], 8'(cur_tag_q),
                                                   cfg_requester_id)
                                : '0;
   assign err       = drop_err_q || tag_err;

endmodule

// File: tb/tb_pcie_mem_req_splitter.sv
module tb_pcie_mem_req_splitter;
   localparam int TAG_COUNT = 32;
   localparam int TAG_W     = 5;

   logic               clk = 1'b0;
   logic               rst = 1'b1;
   logic [15:0]        cfg_requester_id = 16'hA1B2;
   logic               req_valid = 1'b0;
   logic               req_ready;
   logic               req_is_write = 1'b0;
   logic [63:0]        req_addr = '0;
   logic [12:0]        req_len = '0;
   logic               hdr_valid;
   logic               hdr_ready = 1'b1;
   logic [127:0]       hdr;
   logic               hdr_last;
   logic               tag_free_valid = 1'b0;
   logic [TAG_W-1:0]   tag_free = '0;
   logic [TAG_W:0]     tags_in_flight;
   logic               err;

   pcie_mem_req_splitter #(
      .MPS_BYTES(128), .MRRS_BYTES(512), .TAG_COUNT(TAG_COUNT), .LEN_WIDTH(13)
   ) dut (
      .clk(clk), .rst(rst), .cfg_requester_id(cfg_requester_id),
      .req_valid(req_valid), .req_ready(req_ready), .req_is_write(req_is_write),
      .req_addr(req_addr), .req_len(req_len),
      .hdr_valid(hdr_valid), .hdr_ready(hdr_ready), .hdr(hdr), .hdr_last(hdr_last),
      .tag_free_valid(tag_free_valid), .tag_free(tag_free),
      .tags_in_flight(tags_in_flight), .err(err)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [63:0] addr;
      int          len_dw;
      bit          wr;
      int          tag;
      bit          last;
   } exp_t;

   exp_t sbq[$];
   bit   tb_busy[TAG_COUNT];
   int   tests = 0;
   int   fails = 0;

   // Scoreboard: every accepted header is decoded byte by byte and compared.
   always @(negedge clk) begin : mon
      exp_t        e;
      logic [63:0] ga;
      logic [9:0]  glen, elen;
      logic [7:0]  ebe;
      logic [2:0]  efmt;
      logic        zok;
      if (!rst && hdr_valid && hdr_ready) begin
         tests++;
         if (sbq.size() == 0) begin
            fails++;
            $display("FAIL unexpected_hdr got=%h want=none", hdr);
         end else begin
            e    = sbq.pop_front();
            ga   = {hdr[71:64], hdr[79:72], hdr[87:80], hdr[95:88],
                    hdr[103:96], hdr[111:104], hdr[119:112], hdr[127:122], 2'b00};
            glen = {hdr[17:16], hdr[31:24]};
            elen = 10'(e.len_dw % 1024);
            ebe  = (e.len_dw > 1) ? 8'hFF : 8'h0F;
            efmt = e.wr ? 3'b011 : 3'b001;
            zok  = (hdr[4:0] == 5'd0) && (hdr[15:8] == 8'd0) &&
                   (hdr[23:18] == 6'd0) && (hdr[121:120] == 2'd0);
            if (ga !== e.addr || glen !== elen || hdr[7:5] !== efmt ||
                hdr[63:56] !== ebe || hdr[55:48] !== 8'(e.tag) ||
                hdr_last !== e.last || hdr[39:32] !== 8'hA1 ||
                hdr[47:40] !== 8'hB2 || !zok) begin
               fails++;
               $display("FAIL hdr got addr=%h len=%0d fmt=%b be=%h tag=%0d last=%b rid=%h_%h zero=%b want addr=%h len=%0d fmt=%b be=%h tag=%0d last=%b rid=a1_b2 zero=1",
                        ga, glen, hdr[7:5], hdr[63:56], hdr[55:48], hdr_last,
                        hdr[39:32], hdr[47:40], zok,
                        e.addr, elen, efmt, ebe, e.tag, e.last);
            end
         end
      end
   end

   // Reference split: min(remaining, MPS/MRRS, bytes to 4 KB), lowest free tag.
   task automatic push_model(input logic [63:0] a0, input int len, input bit wr);
      logic [63:0] a = a0;
      int          rem = len;
      int          c, bnd, mx;
      exp_t        e;
      while (rem > 0) begin
         mx  = wr ? 128 : 512;
         bnd = 4096 - int'(a[11:0]);
         c   = rem;
         if (mx < c)  c = mx;
         if (bnd < c) c = bnd;
         e.addr = a; e.len_dw = c / 4; e.wr = wr; e.last = (rem == c); e.tag = 0;
         if (!wr) begin
            e.tag = -1;
            for (int t = 0; t < TAG_COUNT; t++)
               if (!tb_busy[t]) begin e.tag = t; break; end
            if (e.tag >= 0) tb_busy[e.tag] = 1'b1;
         end
         sbq.push_back(e);
         a   += 64'(c);
         rem -= c;
      end
   endtask

   task automatic send_req(input logic [63:0] a, input int len, input bit wr,
                           input bit model);
      int n = 0;
      @(posedge clk); #1;
      while (!req_ready && n < 200) begin @(posedge clk); #1; n++; end
      tests++;
      if (!req_ready) begin
         fails++;
         $display("FAIL req_ready_wait got=%b want=1", req_ready);
      end
      if (model) push_model(a, len, wr);
      req_valid = 1'b1; req_addr = a; req_len = 13'(len); req_is_write = wr;
      @(posedge clk); #1;
      req_valid = 1'b0;
   endtask

   task automatic do_free(input int t);
      @(posedge clk); #1;
      tag_free_valid = 1'b1; tag_free = TAG_W'(t);
      @(posedge clk); #1;
      tag_free_valid = 1'b0;
      tb_busy[t] = 1'b0;
   endtask

   task automatic wait_drain(input string name);
      int n = 0;
      while (!(sbq.size() == 0 && req_ready && !hdr_valid) && n < 500) begin
         @(negedge clk); n++;
      end
      tests++;
      if (sbq.size() != 0 || !req_ready) begin
         fails++;
         $display("FAIL %s_drain got pending=%0d ready=%b want pending=0 ready=1",
                  name, sbq.size(), req_ready);
      end
   endtask

   task automatic check_inflight(input string name, input int want);
      @(negedge clk);
      tests++;
      if (tags_in_flight !== (TAG_W + 1)'(want)) begin
         fails++;
         $display("FAIL %s_inflight got=%0d want=%0d", name, tags_in_flight, want);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      tests++;
      if (req_ready !== 1'b1 || hdr_valid !== 1'b0 || hdr !== '0 ||
          hdr_last !== 1'b0 || tags_in_flight !== '0 || err !== 1'b0) begin
         fails++;
         $display("FAIL reset got ready=%b valid=%b hdr=%h last=%b inflight=%0d err=%b want 1 0 0 0 0 0",
                  req_ready, hdr_valid, hdr, hdr_last, tags_in_flight, err);
      end
      @(posedge clk); #1;
      rst = 1'b0;
   endtask

   task automatic test_write_split();
      send_req(64'h1000, 512, 1'b1, 1'b1);
      @(negedge clk);
      tests++;
      if (hdr_valid !== 1'b0 || req_ready !== 1'b0) begin
         fails++;
         $display("FAIL wr_alloc_cycle got valid=%b ready=%b want valid=0 ready=0",
                  hdr_valid, req_ready);
      end
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         tests++;
         if (hdr_valid !== 1'b1) begin
            fails++;
            $display("FAIL wr_consecutive_%0d got=%b want=1", i, hdr_valid);
         end
      end
      @(negedge clk);
      tests++;
      if (hdr_valid !== 1'b0 || req_ready !== 1'b1) begin
         fails++;
         $display("FAIL wr_done got valid=%b ready=%b want valid=0 ready=1",
                  hdr_valid, req_ready);
      end
   endtask

   task automatic test_read_4k_cross();
      send_req(64'h0FC0, 1024, 1'b0, 1'b1);
      wait_drain("rd_cross");
      check_inflight("rd_cross", 3);
      for (int t = 0; t < 3; t++) do_free(t);
      check_inflight("rd_cross_freed", 0);
   endtask

   task automatic test_read_single();
      send_req(64'h20, 4, 1'b0, 1'b1);
      wait_drain("rd_single");
      check_inflight("rd_single", 1);
      do_free(0);
      @(negedge clk);
      tests++;
      if (tags_in_flight !== '0 || err !== 1'b0) begin
         fails++;
         $display("FAIL rd_single_free got inflight=%0d err=%b want inflight=0 err=0",
                  tags_in_flight, err);
      end
   endtask

   task automatic test_tag_exhaust();
      exp_t e;
      bit   stalled_ok = 1'b1;
      for (int i = 0; i < 32; i++) send_req(64'(32'h100 + 4 * i), 4, 1'b0, 1'b1);
      send_req(64'h200, 4, 1'b0, 1'b0);
      repeat (5) begin
         @(negedge clk);
         if (hdr_valid !== 1'b0) stalled_ok = 1'b0;
      end
      tests++;
      if (!stalled_ok || sbq.size() != 0 || tags_in_flight !== 6'd32) begin
         fails++;
         $display("FAIL exhaust_stall got stalled=%b pending=%0d inflight=%0d want stalled=1 pending=0 inflight=32",
                  stalled_ok, sbq.size(), tags_in_flight);
      end
      e.addr = 64'h200; e.len_dw = 1; e.wr = 1'b0; e.tag = 5; e.last = 1'b1;
      sbq.push_back(e);
      do_free(5);
      tb_busy[5] = 1'b1;
      wait_drain("exhaust");
      check_inflight("exhaust_after", 32);
      for (int t = 0; t < TAG_COUNT; t++) do_free(t);
      check_inflight("exhaust_freed", 0);
   endtask

   task automatic test_errors();
      logic [63:0] addrs[4];
      int          lens[4];
      addrs = '{64'h100, 64'h2, 64'h100, 64'h100};
      lens  = '{6, 4, 0, 4100};
      for (int i = 0; i < 4; i++) begin
         send_req(addrs[i], lens[i], 1'b0, 1'b0);
         @(negedge clk);
         tests++;
         if (err !== 1'b1 || hdr_valid !== 1'b0 || req_ready !== 1'b1) begin
            fails++;
            $display("FAIL drop_%0d got err=%b valid=%b ready=%b want err=1 valid=0 ready=1",
                     i, err, hdr_valid, req_ready);
         end
         @(negedge clk);
         tests++;
         if (err !== 1'b0) begin
            fails++;
            $display("FAIL drop_pulse_%0d got err=%b want=0", i, err);
         end
      end
      do_free(7);
      @(negedge clk);
      tests++;
      if (err !== 1'b1 || tags_in_flight !== '0) begin
         fails++;
         $display("FAIL illegal_free got err=%b inflight=%0d want err=1 inflight=0",
                  err, tags_in_flight);
      end
   endtask

   task automatic test_backpressure();
      logic [127:0] h0;
      logic         l0;
      int           n = 0;
      hdr_ready = 1'b1;
      send_req(64'hDEADBEEF_00000F00, 512, 1'b1, 1'b1);
      @(negedge clk);
      while (!hdr_valid && n < 50) begin @(negedge clk); n++; end
      @(posedge clk); #1;
      hdr_ready = 1'b0;
      @(negedge clk);
      h0 = hdr; l0 = hdr_last;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         tests++;
         if (hdr !== h0 || hdr_last !== l0 || hdr_valid !== 1'b1) begin
            fails++;
            $display("FAIL stall_%0d got hdr=%h last=%b valid=%b want hdr=%h last=%b valid=1",
                     i, hdr, hdr_last, hdr_valid, h0, l0);
         end
      end
      @(posedge clk); #1;
      hdr_ready = 1'b1;
      wait_drain("backpressure");
   endtask

   task automatic test_reset_mid_split();
      int  n = 0;
      bit  quiet = 1'b1;
      hdr_ready = 1'b0;
      send_req(64'h0, 2048, 1'b0, 1'b0);
      @(negedge clk);
      while (!hdr_valid && n < 50) begin @(negedge clk); n++; end
      tests++;
      if (tags_in_flight !== 6'd1 || hdr_valid !== 1'b1) begin
         fails++;
         $display("FAIL mid_split_pre got inflight=%0d valid=%b want inflight=1 valid=1",
                  tags_in_flight, hdr_valid);
      end
      @(posedge clk); #1;
      rst = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      tests++;
      if (req_ready !== 1'b1 || hdr_valid !== 1'b0 || hdr !== '0 ||
          hdr_last !== 1'b0 || tags_in_flight !== '0 || err !== 1'b0) begin
         fails++;
         $display("FAIL mid_reset got ready=%b valid=%b hdr=%h last=%b inflight=%0d err=%b want 1 0 0 0 0 0",
                  req_ready, hdr_valid, hdr, hdr_last, tags_in_flight, err);
      end
      @(posedge clk); #1;
      rst = 1'b0;
      for (int t = 0; t < TAG_COUNT; t++) tb_busy[t] = 1'b0;
      hdr_ready = 1'b1;
      repeat (5) begin
         @(negedge clk);
         if (hdr_valid !== 1'b0) quiet = 1'b0;
      end
      tests++;
      if (!quiet) begin
         fails++;
         $display("FAIL post_reset_quiet got headers want none");
      end
      send_req(64'h40, 4, 1'b0, 1'b1);
      wait_drain("post_reset");
      check_inflight("post_reset", 1);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog got=timeout want=finish");
      $fatal(1);
   end

   initial begin
      test_reset();
      test_write_split();
      test_read_4k_cross();
      test_read_single();
      test_tag_exhaust();
      test_errors();
      test_backpressure();
      test_reset_mid_split();
      repeat (2) @(posedge clk);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
